user_btn_rx: RTL and testbench
==============================

# user_btn_rx

Input-side companion to the user LED driver: samples the board's active-low push-buttons in the `OSC_50m` domain. Each button is synchronised and debounced, and the block detects press, release and long-press. The resulting events go through a small FIFO to fabric logic over a valid/ready interface. It sits between the button pins and any controller that reacts to user input, such as LED pattern selection.

## Interface
- `BTN_W`, 4: number of buttons, 2..16.
- `DB_W`, 15: debounce counter width; a level must be stable for 2^DB_W cycles (655 µs at 50 MHz).
- `LP_W`, 25: long-press counter width; threshold is 2^LP_W cycles (0.67 s).
- `FIFO_D`, 4: event FIFO depth, a power of two ≥ 2.
- `OSC_50m`, in, 1: 50 MHz clock.
- `FPGA_RSTn`, in, 1: reset, asynchronous, active-low.
- `USER_BTNn`, in, BTN_W: raw button pins, 0 = pressed, asynchronous to clock.
- `btn_state`, out, BTN_W: debounced state, 1 = pressed.
- `evt_valid`, out, 1: FIFO head holds an event.
- `evt_ready`, in, 1: consumer accepts the head event.
- `evt_code`, out, 2: head event type; 00 press, 01 release, 10 long-press, 11 unused.
- `evt_id`, out, $clog2(BTN_W): button index of the head event.
- `evt_ovf`, out, 1: sticky overflow flag, cleared only by reset.

## Operation
- **Reset:**
  - `FPGA_RSTn` low asynchronously clears a 2-flop reset synchroniser.
  - Internal reset deasserts on the 2nd rising edge after `FPGA_RSTn` rises.
  - All state uses this internal reset.
- **Input sync:**
  - Each `USER_BTNn` bit passes through a 2-flop synchroniser, which resets to 1 (released).
  - The synchronised value is inverted to give an active-high `s`.
- **Debounce (per button):**
  - If `s` equals `stable`, `db_cnt` is cleared to 0.
  - Else, if `db_cnt` is all-ones: `stable` is set to `s`, `db_cnt` is cleared to 0, and pending press (rising) or pending release (falling) is set.
  - Else, `db_cnt` is incremented.
  - Any single-cycle return to `stable` restarts the count.
- **Long-press (per button):**
  - While `stable` = 1, `lp_cnt` increments and saturates at all-ones.
  - On the cycle it reaches all-ones, pending long-press is set, exactly once per press.
  - `stable` = 0 clears `lp_cnt`.
- **Pending bits:**
  - There are 3 per button.
  - Setting a bit that is already set also sets `evt_ovf`; the event is lost and the bit stays set.
- **Arbiter:**
  - Each cycle, if FIFO count < FIFO_D, it selects the lowest-index button with any pending bit.
  - Within that button the order is press, then long, then release.
  - The selected event is written and its pending bit is cleared.
  - At most one write per cycle.
  - A pending bit being set and cleared on the same edge resolves to set, because it is a new event.
- **FIFO:**
  - Circular buffer with read/write pointers plus a count.
  - `evt_code`/`evt_id` are driven from the entry at the read pointer.
  - `evt_valid` = (count ≠ 0).
  - A pop happens on `evt_valid && evt_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - When full, no write occurs even if a pop happens that cycle; there is no pass-through.
- **`btn_state`** equals `stable`.

## Timing
- **Reset values:**
  - `btn_state` = 0, `evt_valid` = 0, `evt_ovf` = 0.
  - `evt_code`/`evt_id` = 0; all FIFO entries are cleared.
  - All counters and pending bits = 0.
- **Latency:**
  - A clean pin edge sampled at edge E reaches `s` at E+2.
  - `btn_state` changes at E+2+2^DB_W.
  - The pending bit is set on that same edge.
  - The FIFO write happens on the next edge; with the FIFO empty and no contention, `evt_valid` rises 1 cycle after `btn_state`.
- **Long-press:**
  - The long-press event is pended 2^LP_W−1 cycles after `btn_state` rises.
  - Since `lp_cnt` counts from 0, it first reaches all-ones 2^LP_W−1 cycles later.
- **Handshake:** `evt_valid` stays high and the head entry stays stable until accepted; `evt_ready` may be held constantly high.
- **Buttons held through reset** produce a press event after the normal debounce delay once reset releases.
- **Reset mid-operation** discards all FIFO contents and pending events immediately (asynchronous assert).

## Test plan
Unless stated, tests use `DB_W` = 3, `LP_W` = 5, `BTN_W` = 4, `FIFO_D` = 4 and `evt_ready` = 1.
- **Clean press:** button 2 driven low → `btn_state` = 0100 exactly 10 cycles after the edge is sampled, then `evt_valid` for 1 cycle with code 00 and id 2. Release → code 01, id 2.
- **Bounce:** the pin toggles every 5 cycles for 60 cycles, then holds low → no event during bouncing; exactly one press, 8 cycles after the last toggle is synchronised.
- **Long-press:** hold button 0 for 100 cycles after debounce → events in order: press, long (31 cycles after `btn_state` rises), release. Only one long event.
- **Simultaneous:** buttons 3 and 1 pressed on the same cycle → press for id 1 on consecutive cycles, then id 3.
- **Backpressure and overflow:**
  - Setup: `evt_ready` = 0; press and release buttons 0–3 to generate 8 events.
  - Ordering and full: FIFO fills at 4 entries; the head stays constant. Events are then read in arbiter order, with nothing duplicated.
  - Overflow: a repeated press on an already-pending button sets `evt_ovf` = 1, which stays set until reset.
- **Reset mid-stream:** `FPGA_RSTn` pulsed low with 3 events queued → `evt_valid` = 0 at once, `btn_state` = 0. With button 1 held through reset, a press for id 1 arrives 2+2+8 cycles after release.

Source files
------------

// File: rtl/user_btn_rx.sv
// -----------------------------------------------------------------------------
// user_btn_rx
//   Push-button receiver. Active-low buttons are synchronised, debounced and
//   turned into press / release / long-press events, which are queued in a
//   small FIFO and delivered to fabric logic over a valid/ready interface.
//
// Ports
//   OSC_50m    in   system clock
//   FPGA_RSTn  in   async active-low reset (synchronised internally)
//   USER_BTNn  in   raw button pins, 0 = pressed, asynchronous
//   btn_state  out  debounced button state, 1 = pressed
//   evt_valid  out  FIFO head holds an event
//   evt_ready  in   consumer accepts the head event
//   evt_code   out  head event type: 00 press, 01 release, 10 long-press
//   evt_id     out  button index of the head event
//   evt_ovf    out  sticky: an event was lost because its pending bit was set
// -----------------------------------------------------------------------------
module user_btn_rx #(
  parameter int BTN_W  = 4,
  parameter int DB_W   = 15,
  parameter int LP_W   = 25,
  parameter int FIFO_D = 4
) (
  input  logic                       OSC_50m,
  input  logic                       FPGA_RSTn,
  input  logic [BTN_W-1:0]           USER_BTNn,
  output logic [BTN_W-1:0]           btn_state,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [1:0]                 evt_code,
  output logic [$clog2(BTN_W)-1:0]   evt_id,
  output logic                       evt_ovf
);

  localparam int ID_W  = $clog2(BTN_W);
  localparam int EW    = ID_W + 2;
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_D);
  localparam logic [LP_W-1:0]  LP_PRE_MAX = {{(LP_W-1){1'b1}}, 1'b0};

  localparam logic [1:0] CODE_PRESS = 2'b00;
  localparam logic [1:0] CODE_REL   = 2'b01;
  localparam logic [1:0] CODE_LONG  = 2'b10;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: asserts asynchronously, releases on the 2nd clock edge
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
    if (!FPGA_RSTn) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Input synchroniser (resets to released) and polarity flip
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0] sync1_q, sync2_q;
  logic [BTN_W-1:0] s;

  always_ff @(posedge OSC_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= USER_BTNn;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce, long-press timers and event detection
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0] stable_q, stable_d;
  logic [DB_W-1:0]  db_cnt_q [BTN_W];
  logic [DB_W-1:0]  db_cnt_d [BTN_W];
  logic [LP_W-1:0]  lp_cnt_q [BTN_W];
  logic [LP_W-1:0]  lp_cnt_d [BTN_W];
  logic [BTN_W-1:0] set_press, set_rel, set_long;

  always_comb begin
    stable_d  = stable_q;
    set_press = '0;
    set_rel   = '0;
    set_long  = '0;
    for (int i = 0; i < BTN_W; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      lp_cnt_d[i] = lp_cnt_q[i];

      if (s[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (&db_cnt_q[i]) begin
        stable_d[i]  = s[i];
        db_cnt_d[i]  = '0;
        set_press[i] = s[i];
        set_rel[i]   = ~s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end

      // Saturating counter: the long event fires only on the step into all-ones
      if (!stable_q[i]) begin
        lp_cnt_d[i] = '0;
      end else if (!(&lp_cnt_q[i])) begin
        lp_cnt_d[i] = lp_cnt_q[i] + 1'b1;
        if (lp_cnt_q[i] == LP_PRE_MAX) set_long[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge OSC_50m or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < BTN_W; i++) begin
        db_cnt_q[i] <= '0;
        lp_cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < BTN_W; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        lp_cnt_q[i] <= lp_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter: lowest button first; press, then long, then release
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0] pend_press_q, pend_press_d;
  logic [BTN_W-1:0] pend_rel_q,   pend_rel_d;
  logic [BTN_W-1:0] pend_long_q,  pend_long_d;
  logic [BTN_W-1:0] clr_press, clr_rel, clr_long;
  logic             ovf_q, ovf_d;
  logic             arb_found;
  logic [ID_W-1:0]  arb_id;
  logic [1:0]       arb_code;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_code  = CODE_PRESS;
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    if (count_q != FIFO_FULL) begin
      for (int i = 0; i < BTN_W; i++) begin
        if (!arb_found && (pend_press_q[i] || pend_long_q[i] || pend_rel_q[i])) begin
          arb_found = 1'b1;
          arb_id    = ID_W'(i);
          if (pend_press_q[i]) begin
            arb_code     = CODE_PRESS;
            clr_press[i] = 1'b1;
          end else if (pend_long_q[i]) begin
            arb_code     = CODE_LONG;
            clr_long[i]  = 1'b1;
          end else begin
            arb_code     = CODE_REL;
            clr_rel[i]   = 1'b1;
          end
        end
      end
    end
  end

  // A set on the same edge as a clear wins: it is a fresh event. Overflow is
  // flagged only when the existing event is not leaving this cycle, i.e. when
  // one is actually lost.
  always_comb begin
    pend_press_d = (pend_press_q & ~clr_press) | set_press;
    pend_rel_d   = (pend_rel_q   & ~clr_rel)   | set_rel;
    pend_long_d  = (pend_long_q  & ~clr_long)  | set_long;
    ovf_d        = ovf_q
                 | (|(set_press & pend_press_q & ~clr_press))
                 | (|(set_rel   & pend_rel_q   & ~clr_rel))
                 | (|(set_long  & pend_long_q  & ~clr_long));
  end

  always_ff @(posedge OSC_50m or negedge rst_n) begin
    if (!rst_n) begin
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      pend_long_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      pend_long_q  <= pend_long_d;
      ovf_q        <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO. Push is gated on the current count, so a full FIFO never
  // accepts a write even when it is being popped on the same edge.
  // ---------------------------------------------------------------------------
  logic [EW-1:0]    mem_q [FIFO_D];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_d;
  logic             push, pop;
  logic [EW-1:0]    head;

  assign push = arb_found;
  assign pop  = evt_valid && evt_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge OSC_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {arb_code, arb_id};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign evt_valid = (count_q != '0);
  assign evt_code  = head[EW-1 -: 2];
  assign evt_id    = head[ID_W-1:0];
  assign evt_ovf   = ovf_q;
  assign btn_state = stable_q;

endmodule

// File: tb/tb_user_btn_rx.sv
// -----------------------------------------------------------------------------
// tb_user_btn_rx
//   Directed bench for user_btn_rx with short debounce (2^3) and long-press
//   (2^5) thresholds. Inputs change 1 time unit after a rising edge; outputs
//   are checked at the same point, so "step(n)" lands just after edge k+n.
// -----------------------------------------------------------------------------
module tb_user_btn_rx;

  logic       clk;
  logic       rst_n_pin;
  logic [3:0] btn_n;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic [1:0] evt_id;
  logic       evt_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  user_btn_rx #(
    .BTN_W (4),
    .DB_W  (3),
    .LP_W  (5),
    .FIFO_D(4)
  ) dut (
    .OSC_50m  (clk),
    .FPGA_RSTn(rst_n_pin),
    .USER_BTNn(btn_n),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_id   (evt_id),
    .evt_ovf  (evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drain order after backpressure: FIFO holds the four presses; then button 0
  // has a new press and a release pending (press first), then releases 1..3.
  logic [1:0] drain_code [9];
  logic [1:0] drain_id   [9];
  int         cnt;

  initial begin
    drain_code = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    drain_id   = '{2'd0,  2'd1,  2'd2,  2'd3,  2'd0,  2'd0,  2'd1,  2'd2,  2'd3};

    // ---------------- reset ----------------
    rst_n_pin = 1'b1;
    btn_n     = 4'b1111;
    evt_ready = 1'b1;
    #2 rst_n_pin = 1'b0;
    step(3);
    chk("rst_btn_state", btn_state, 4'b0000);
    chk("rst_evt_valid", evt_valid, 1'b0);
    chk("rst_evt_ovf",   evt_ovf,   1'b0);
    chk("rst_evt_code",  evt_code,  2'b00);
    chk("rst_evt_id",    evt_id,    2'd0);
    rst_n_pin = 1'b1;
    step(4);

    // ---------------- clean press / release on button 2 ----------------
    btn_n[2] = 1'b0;
    step(9);
    chk("press2_early", btn_state, 4'b0000);
    step(1);
    chk("press2_state", btn_state, 4'b0100);
    chk("press2_novalid", evt_valid, 1'b0);
    step(1);
    chk("press2_valid", evt_valid, 1'b1);
    chk("press2_code",  evt_code,  2'b00);
    chk("press2_id",    evt_id,    2'd2);
    step(1);
    chk("press2_popped", evt_valid, 1'b0);
    btn_n[2] = 1'b1;
    step(10);
    chk("rel2_state", btn_state, 4'b0000);
    step(1);
    chk("rel2_valid", evt_valid, 1'b1);
    chk("rel2_code",  evt_code,  2'b01);
    chk("rel2_id",    evt_id,    2'd2);
    step(1);
    chk("rel2_popped", evt_valid, 1'b0);

    // ---------------- bounce on button 0, then long hold ----------------
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      btn_n[0] = (i % 2 == 1);
      for (int j = 0; j < 5; j++) begin
        step(1);
        if (evt_valid || btn_state[0]) cnt++;
      end
    end
    chk("bounce_quiet", cnt, 0);
    btn_n[0] = 1'b0;
    step(9);
    chk("bounce_early", btn_state, 4'b0000);
    step(1);
    chk("bounce_state", btn_state, 4'b0001);
    step(1);
    chk("bounce_valid", evt_valid, 1'b1);
    chk("bounce_code",  evt_code,  2'b00);
    chk("bounce_id",    evt_id,    2'd0);
    // btn_state rose at B; now at B+1. Long pends at B+31, visible at B+32.
    step(30);
    chk("long_not_yet", evt_valid, 1'b0);
    step(1);
    chk("long_valid", evt_valid, 1'b1);
    chk("long_code",  evt_code,  2'b10);
    chk("long_id",    evt_id,    2'd0);
    cnt = 0;
    for (int i = 0; i < 68; i++) begin
      step(1);
      if (evt_valid) cnt++;
    end
    chk("long_once", cnt, 0);
    btn_n[0] = 1'b1;
    step(10);
    chk("rel0_state", btn_state, 4'b0000);
    step(1);
    chk("rel0_valid", evt_valid, 1'b1);
    chk("rel0_code",  evt_code,  2'b01);
    chk("rel0_id",    evt_id,    2'd0);
    step(1);
    chk("rel0_popped", evt_valid, 1'b0);

    // ---------------- simultaneous buttons 3 and 1 ----------------
    btn_n = 4'b0101;
    step(10);
    chk("sim_state", btn_state, 4'b1010);
    step(1);
    chk("sim_a_valid", evt_valid, 1'b1);
    chk("sim_a_code",  evt_code,  2'b00);
    chk("sim_a_id",    evt_id,    2'd1);
    step(1);
    chk("sim_b_valid", evt_valid, 1'b1);
    chk("sim_b_code",  evt_code,  2'b00);
    chk("sim_b_id",    evt_id,    2'd3);
    step(1);
    chk("sim_empty", evt_valid, 1'b0);
    btn_n = 4'b1111;
    step(10);
    chk("sim_rel_state", btn_state, 4'b0000);
    step(1);
    chk("sim_rel_a_code", evt_code, 2'b01);
    chk("sim_rel_a_id",   evt_id,   2'd1);
    step(1);
    chk("sim_rel_b_code", evt_code, 2'b01);
    chk("sim_rel_b_id",   evt_id,   2'd3);
    step(1);
    chk("sim_rel_empty", evt_valid, 1'b0);

    // ---------------- backpressure and overflow ----------------
    evt_ready = 1'b0;
    btn_n = 4'b0000;
    step(10);
    chk("bp_state", btn_state, 4'b1111);
    step(1);
    chk("bp_head_valid", evt_valid, 1'b1);
    chk("bp_head_id0",   evt_id,    2'd0);
    step(3);
    chk("bp_full_code", evt_code, 2'b00);
    chk("bp_full_id",   evt_id,   2'd0);
    btn_n = 4'b1111;
    step(10);
    chk("bp_rel_state", btn_state, 4'b0000);
    chk("bp_no_ovf_a",  evt_ovf,   1'b0);
    btn_n[0] = 1'b0;
    step(10);
    chk("bp_repress", btn_state, 4'b0001);
    chk("bp_no_ovf_b", evt_ovf,  1'b0);
    btn_n[0] = 1'b1;
    step(9);
    chk("bp_no_ovf_c", evt_ovf, 1'b0);
    step(1);
    chk("bp_ovf_set",  evt_ovf, 1'b1);
    chk("bp_head_still", evt_id, 2'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("drain%0d_valid", i), evt_valid, 1'b1);
      chk($sformatf("drain%0d_code", i),  evt_code,  drain_code[i]);
      chk($sformatf("drain%0d_id", i),    evt_id,    drain_id[i]);
      step(1);
    end
    chk("drain_empty", evt_valid, 1'b0);
    step(5);
    chk("ovf_sticky", evt_ovf, 1'b1);

    // ---------------- reset mid-stream ----------------
    evt_ready = 1'b0;
    btn_n = 4'b1000;
    step(10);
    chk("mid_state", btn_state, 4'b0111);
    step(3);
    chk("mid_queued", evt_valid, 1'b1);
    rst_n_pin = 1'b0;
    #1;
    chk("mid_rst_valid", evt_valid, 1'b0);
    chk("mid_rst_state", btn_state, 4'b0000);
    chk("mid_rst_ovf",   evt_ovf,   1'b0);
    btn_n = 4'b1101;
    step(2);
    rst_n_pin = 1'b1;
    evt_ready = 1'b1;
    step(11);
    chk("held_early", btn_state, 4'b0000);
    step(1);
    chk("held_state", btn_state, 4'b0010);
    step(1);
    chk("held_valid", evt_valid, 1'b1);
    chk("held_code",  evt_code,  2'b00);
    chk("held_id",    evt_id,    2'd1);
    step(1);
    chk("held_popped", evt_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
